arp_tx: RTL

ARP frame transmitter: the send side paired with the ARP cache. It builds ARP reply frames for requests received from peers and ARP request frames for IP addresses that missed in the cache. Each frame is serialized MSB-first onto an 8-bit AXI-Stream master that feeds the Ethernet MAC TX path. Local MAC and IP addresses come from the configuration interface.

---
 rtl/arp_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/arp_tx.sv
// ARP frame transmitter: serializes ARP reply/request frames MSB-first onto an 8-bit AXI-Stream master.
// Optional build macro ARP_TX_PAD_EN appends 18 zero bytes so the frame reaches the 60-byte Ethernet minimum.
module arp_tx #(
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [47:0] mac_config_addr,
  input  logic [31:0] ip_config_addr,
  input  logic        reply_req,
  input  logic [47:0] reply_mac,
  input  logic [31:0] reply_ip,
  output logic        reply_ack,
  input  logic        request_req,
  input  logic [31:0] request_ip,
  output logic        request_ack,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy
);

`ifdef ARP_TX_PAD_EN
  localparam int unsigned FRAME_LEN = 60;
`else
  localparam int unsigned FRAME_LEN = 42;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_IFG} state_t;

  state_t             state, state_n;
  logic [5:0]         cnt;
  logic [IFG_W-1:0]   ifg_cnt;
  logic               ifg_done;
  logic               lat_reply;
  logic [47:0]        lat_peer_mac;
  logic [31:0]        lat_tpa;
  logic [47:0]        lat_mac;
  logic [31:0]        lat_ip;
  logic [5:0]         cnt_inc;

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int unsigned i);
    return 8'(mac >> (8 * (5 - i)));
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input int unsigned i);
    return 8'(ip >> (8 * (3 - i)));
  endfunction

  // peer_mac supplies both the Ethernet destination and THA for replies only
  function automatic logic [7:0] frame_byte(input logic [5:0] idx, input logic is_reply,
                                            input logic [47:0] peer_mac, input logic [31:0] tpa,
                                            input logic [47:0] my_mac, input logic [31:0] my_ip);
    int unsigned i;
    logic [7:0] b;
    i = 32'(idx);
    b = '0;
    if (i < 6)       b = is_reply ? mac_byte(peer_mac, i) : 8'hFF;
    else if (i < 12) b = mac_byte(my_mac, i - 6);
    else if (i < 22) begin
      case (i)
        12:      b = 8'h08;
        13:      b = 8'h06;
        15:      b = 8'h01;
        16:      b = 8'h08;
        18:      b = 8'h06;
        19:      b = 8'h04;
        21:      b = is_reply ? 8'h02 : 8'h01;
        default: b = 8'h00;
      endcase
    end
    else if (i < 28) b = mac_byte(my_mac, i - 22);
    else if (i < 32) b = ip_byte(my_ip, i - 28);
    else if (i < 38) b = is_reply ? mac_byte(peer_mac, i - 32) : 8'h00;
    else if (i < 42) b = ip_byte(tpa, i - 38);
    return b;
  endfunction

  assign cnt_inc  = cnt + 6'd1;
  assign ifg_done = (32'(ifg_cnt) == IFG_CYCLES - 32'd1);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (reply_req || request_req) state_n = S_SEND;
      S_SEND: if (m_axis_tready && cnt == LAST_IDX) state_n = (IFG_CYCLES != 0) ? S_IFG : S_IDLE;
      S_IFG:  if (ifg_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Byte 0 is built straight from the inputs so it can be presented in the ack cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt           <= '0;
      ifg_cnt       <= '0;
      lat_reply     <= 1'b0;
      lat_peer_mac  <= '0;
      lat_tpa       <= '0;
      lat_mac       <= '0;
      lat_ip        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      reply_ack     <= 1'b0;
      request_ack   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      reply_ack   <= 1'b0;
      request_ack <= 1'b0;
      busy        <= (state_n != S_IDLE);
      case (state)
        S_IDLE: begin
          if (reply_req) begin
            lat_reply     <= 1'b1;
            lat_peer_mac  <= reply_mac;
            lat_tpa       <= reply_ip;
            lat_mac       <= mac_config_addr;
            lat_ip        <= ip_config_addr;
            reply_ack     <= 1'b1;
            cnt           <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= frame_byte(6'd0, 1'b1, reply_mac, reply_ip,
                                        mac_config_addr, ip_config_addr);
          end else if (request_req) begin
            lat_reply     <= 1'b0;
            lat_peer_mac  <= '0;
            lat_tpa       <= request_ip;
            lat_mac       <= mac_config_addr;
            lat_ip        <= ip_config_addr;
            request_ack   <= 1'b1;
            cnt           <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= frame_byte(6'd0, 1'b0, '0, request_ip,
                                        mac_config_addr, ip_config_addr);
          end
        end
        S_SEND: begin
          if (m_axis_tready) begin
            if (cnt == LAST_IDX) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              ifg_cnt       <= '0;
            end else begin
              cnt          <= cnt_inc;
              m_axis_tdata <= frame_byte(cnt_inc, lat_reply, lat_peer_mac, lat_tpa,
                                         lat_mac, lat_ip);
              m_axis_tlast <= (cnt_inc == LAST_IDX);
            end
          end
        end
        S_IFG: ifg_cnt <= ifg_cnt + IFG_W'(1);
        default: ;
      endcase
    end
  end

endmodule
